// File: rtl/mem_access_unit.sv
// Storage stage of the memory project: accepts one read/write command per handshake,
// spends LAT cycles in ACCESS, then reports completion with a one-cycle done pulse.
module mem_access_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 12,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              in_range;

  // Extra MSB keeps the compare exact even when DEPTH equals 2^ADDR_W
  assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            lat_rw    <= rw;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
            // Out-of-range commands leave both the array and rdata untouched
            if (in_range) begin
              err <= 1'b0;
              if (lat_rw) begin
                mem[lat_addr] <= lat_wdata;
              end else begin
                rdata <= mem[lat_addr];
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: unit 0 uses DEPTH=12/LAT=2, unit 1 uses DEPTH=16/LAT=1.
module tb_mem_access_unit;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       valid [2];
  logic       rw    [2];
  logic [3:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic       done  [2];
  logic       busy  [2];
  logic       err   [2];

  int   nCompared = 0;
  int   nMismatched = 0;
  int   cyc = 0;
  int   doneCount [2] = '{0, 0};
  logic prevDone [2] = '{1'b0, 1'b0};
  int   depthU [2] = '{12, 16};
  int   latU [2] = '{2, 1};

  logic [7:0] mdl [2][16];
  logic [7:0] mrd [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t monE;

  mem_access_unit #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .LAT(2)) dut0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .done(done[0]), .busy(busy[0]), .err(err[0])
  );

  mem_access_unit #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .done(done[1]), .busy(busy[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int u = 0; u < 2; u++) begin
      mrd[u] = 8'h00;
      for (int a = 0; a < 16; a++) mdl[u][a] = 8'h00;
    end
    q0.delete();
    q1.delete();
  endtask

  function automatic int qSize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  // Predicts the completion of a command and pushes it to that unit's scoreboard
  task automatic pushExpected(input int u, input logic w, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    if (int'(a) < depthU[u]) begin
      if (w) mdl[u][a] = d;
      else   mrd[u] = mdl[u][a];
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.rdata = mrd[u];
    e.acc   = cyc + 1;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic waitIdle(input int u);
    int n = 0;
    while ((qSize(u) != 0 || busy[u] !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", n, 0);
  endtask

  task automatic applyStimulus(input int u, input logic w, input logic [3:0] a, input logic [7:0] d);
    waitIdle(u);
    valid[u] = 1'b1;
    rw[u]    = w;
    addr[u]  = a;
    wdata[u] = d;
    pushExpected(u, w, a, d);
    @(negedge clk);
    valid[u] = 1'b0;
    addr[u]  = 4'($urandom);
    wdata[u] = 8'($urandom);
    checkOutput("busy_after_accept", busy[u], 1);
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done[u] === 1'b1) begin
        doneCount[u]++;
        checkOutput("done_pulse_width", prevDone[u], 0);
        if (qSize(u) == 0) begin
          checkOutput("unexpected_done", done[u], 0);
        end else begin
          monE = (u == 0) ? q0.pop_front() : q1.pop_front();
          checkOutput("rdata", rdata[u], monE.rdata);
          checkOutput("err", err[u], monE.err);
          checkOutput("done_latency", cyc - monE.acc, latU[u]);
          checkOutput("busy_with_done", busy[u], 1);
        end
      end
      prevDone[u] = done[u];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCount;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0; rw[u] = 1'b0; addr[u] = 4'h0; wdata[u] = 8'h00;
    end
    resetModel();

    // Asynchronous reset asserted mid-cycle
    #7 rst = 1'b1;
    #1;
    checkOutput("reset_rdata", rdata[0], 0);
    checkOutput("reset_done", done[0], 0);
    checkOutput("reset_busy", busy[0], 0);
    checkOutput("reset_err", err[0], 0);
    checkOutput("reset_busy_u1", busy[1], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_busy", busy[0], 0);
    checkOutput("idle_done_count", doneCount[0], 0);

    // Write then read back
    applyStimulus(0, 1'b1, 4'd3, 8'hA5);
    applyStimulus(0, 1'b0, 4'd3, 8'h00);
    applyStimulus(0, 1'b1, 4'd0, 8'h3C);
    applyStimulus(0, 1'b1, 4'd11, 8'hC3);

    // Out-of-range write and read, then sweep all implemented words
    applyStimulus(0, 1'b1, 4'd13, 8'hFF);
    applyStimulus(0, 1'b0, 4'd13, 8'h00);
    for (int a = 0; a < 12; a++) applyStimulus(0, 1'b0, 4'(a), 8'h00);
    applyStimulus(0, 1'b0, 4'd15, 8'h00);

    // valid held high: one accept every LAT+2 cycles
    waitIdle(0);
    startCount = doneCount[0];
    valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 4'd5; wdata[0] = 8'h11;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) pushExpected(0, 1'b1, 4'd5, 8'h11);
      @(negedge clk);
    end
    valid[0] = 1'b0;
    waitIdle(0);
    checkOutput("held_valid_accepts", doneCount[0] - startCount, 3);

    // wdata changing during ACCESS must not reach the array
    applyStimulus(0, 1'b1, 4'd5, 8'h44);
    applyStimulus(0, 1'b1, 4'd5, 8'h11);
    valid[0] = 1'b1;
    wdata[0] = 8'h22;
    repeat (3) @(negedge clk);
    valid[0] = 1'b0;
    applyStimulus(0, 1'b0, 4'd5, 8'h00);

    // Reset during ACCESS aborts the write
    applyStimulus(0, 1'b1, 4'd2, 8'h5A);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_done", done[0], 0);
    checkOutput("abort_rdata", rdata[0], 0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1'b0, 4'd2, 8'h00);
    applyStimulus(0, 1'b0, 4'd5, 8'h00);

    // LAT=1, DEPTH=16 unit: boundary addresses
    applyStimulus(1, 1'b1, 4'd0, 8'h5E);
    applyStimulus(1, 1'b1, 4'd11, 8'hE5);
    applyStimulus(1, 1'b1, 4'd15, 8'hF0);
    applyStimulus(1, 1'b0, 4'd0, 8'h00);
    applyStimulus(1, 1'b0, 4'd11, 8'h00);
    applyStimulus(1, 1'b0, 4'd15, 8'h00);
    applyStimulus(1, 1'b0, 4'd7, 8'h00);

    waitIdle(0);
    waitIdle(1);
    checkOutput("pending_u0", q0.size(), 0);
    checkOutput("pending_u1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
